// File: rtl/dsp48a1_mac_sched.sv
// dsp48a1_mac_sched: round-robin scheduler sharing one DSP48A1 MAC slice among NREQ requesters
//   clk, reset          : clock, asynchronous active-high reset
//   i_req_valid/last/sub: per-requester beat valid, final-beat flag, subtract flag
//   i_req_a/i_req_b     : packed 18-bit signed operands, requester i at [18i+17:18i]
//   o_req_ready         : per-requester beat accept (one-hot to the granted requester)
//   o_dsp_*             : opmode and operands to the slice, i_dsp_pout is its P output
//   o_res_*             : one-cycle result strobe with id, 48-bit sum and saturating beat count
//   o_busy              : high whenever a job is in flight
module dsp48a1_mac_sched #(
  parameter int NREQ    = 4,
  parameter int ID_W    = 2,
  parameter int DSP_LAT = 3,
  parameter int CNT_W   = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      i_req_valid,
  output logic [NREQ-1:0]      o_req_ready,
  input  logic [NREQ-1:0]      i_req_last,
  input  logic [NREQ-1:0]      i_req_sub,
  input  logic [NREQ*18-1:0]   i_req_a,
  input  logic [NREQ*18-1:0]   i_req_b,
  output logic [1:0]           o_dsp_opmode_x,
  output logic [1:0]           o_dsp_opmode_z,
  output logic                 o_dsp_postadd_sub,
  output logic [17:0]          o_dsp_a,
  output logic [17:0]          o_dsp_b,
  input  logic [47:0]          i_dsp_pout,
  output logic                 o_res_valid,
  output logic [ID_W-1:0]      o_res_id,
  output logic [47:0]          o_res_data,
  output logic [CNT_W-1:0]     o_res_cnt,
  output logic                 o_busy
);
  localparam int DW = $clog2(DSP_LAT + 1);
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DRAIN, S_DONE} state_t;
  state_t r_state, w_next;
  logic [ID_W-1:0]  r_rr, r_gnt, w_pick;
  logic [CNT_W-1:0] r_cnt;
  logic [DW-1:0]    r_drain;
  logic             r_first;
  logic             r_res_valid;
  logic [ID_W-1:0]  r_res_id;
  logic [47:0]      r_res_data;
  logic [CNT_W-1:0] r_res_cnt;
  logic             w_any, w_acc, w_last, w_sub;
  logic [17:0]      w_a, w_b;
  // Descending scan so the lowest offset from the RR pointer is the last write and wins.
  always_comb begin
    w_any  = 1'b0;
    w_pick = '0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (i_req_valid[(int'(r_rr) + k) % NREQ]) begin
        w_any  = 1'b1;
        w_pick = ID_W'((int'(r_rr) + k) % NREQ);
      end
  end
  assign w_a    = i_req_a[18*int'(r_gnt) +: 18];
  assign w_b    = i_req_b[18*int'(r_gnt) +: 18];
  assign w_last = i_req_last[r_gnt];
  assign w_sub  = i_req_sub[r_gnt];
  assign w_acc  = (r_state == S_BUSY) && i_req_valid[r_gnt];
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state     <= S_IDLE;
      r_rr        <= '0;
      r_gnt       <= '0;
      r_cnt       <= '0;
      r_drain     <= '0;
      r_first     <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_id    <= '0;
      r_res_data  <= '0;
      r_res_cnt   <= '0;
    end else begin
      r_state     <= w_next;
      r_res_valid <= 1'b0;
      if (r_state == S_IDLE && w_any) begin
        r_gnt   <= w_pick;
        r_rr    <= (w_pick == ID_W'(NREQ - 1)) ? '0 : w_pick + 1'b1;
        r_cnt   <= '0;
        r_first <= 1'b1;
      end
      if (w_acc) begin
        r_first <= 1'b0;
        if (r_cnt != '1) r_cnt <= r_cnt + 1'b1;
        if (w_last) r_drain <= DW'(DSP_LAT - 1);
      end
      // pout already reflects the last beat on the final drain cycle, so capture it here
      // and the registered strobe lands in the DONE cycle.
      if (r_state == S_DRAIN) begin
        r_drain <= r_drain - 1'b1;
        if (r_drain == '0) begin
          r_res_valid <= 1'b1;
          r_res_id    <= r_gnt;
          r_res_data  <= i_dsp_pout;
          r_res_cnt   <= r_cnt;
        end
      end
    end
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_next = S_BUSY;
      S_BUSY:  if (w_acc && w_last) w_next = S_DRAIN;
      S_DRAIN: if (r_drain == '0) w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end
  // Anything other than an accepted beat is HOLD (x=0, z=P), which keeps P unchanged.
  always_comb begin
    o_req_ready       = (r_state == S_BUSY) ? NREQ'(1) << r_gnt : '0;
    o_dsp_opmode_x    = w_acc ? 2'b01 : 2'b00;
    o_dsp_opmode_z    = (w_acc && r_first) ? 2'b00 : 2'b10;
    o_dsp_postadd_sub = w_acc & w_sub;
    o_dsp_a           = w_acc ? w_a : '0;
    o_dsp_b           = w_acc ? w_b : '0;
    o_busy            = r_state != S_IDLE;
  end
  assign o_res_valid = r_res_valid;
  assign o_res_id    = r_res_id;
  assign o_res_data  = r_res_data;
  assign o_res_cnt   = r_res_cnt;
endmodule

// File: tb/tb_dsp48a1_mac_sched.sv
// tb_dsp48a1_mac_sched: directed bench for dsp48a1_mac_sched with a behavioural 3-cycle DSP slice
module tb_dsp48a1_mac_sched;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  vld = '0, lst = '0, sb = '0;
  logic [71:0] ra = '0, rb = '0;
  logic [3:0]  o_req_ready;
  logic [1:0]  o_dsp_opmode_x, o_dsp_opmode_z;
  logic        o_dsp_postadd_sub;
  logic [17:0] o_dsp_a, o_dsp_b;
  logic [47:0] pout = '0;
  logic        o_res_valid;
  logic [1:0]  o_res_id;
  logic [47:0] o_res_data;
  logic [7:0]  o_res_cnt;
  logic        o_busy;
  logic [40:0] s1 = '0, s2 = '0;
  int          cyc = 0, t_acc = 0, n_chk = 0, n_fail = 0;
  dsp48a1_mac_sched dut (
    .clk(clk), .reset(reset),
    .i_req_valid(vld), .o_req_ready(o_req_ready), .i_req_last(lst), .i_req_sub(sb),
    .i_req_a(ra), .i_req_b(rb),
    .o_dsp_opmode_x(o_dsp_opmode_x), .o_dsp_opmode_z(o_dsp_opmode_z),
    .o_dsp_postadd_sub(o_dsp_postadd_sub), .o_dsp_a(o_dsp_a), .o_dsp_b(o_dsp_b),
    .i_dsp_pout(pout),
    .o_res_valid(o_res_valid), .o_res_id(o_res_id), .o_res_data(o_res_data),
    .o_res_cnt(o_res_cnt), .o_busy(o_busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [47:0] next_p(input logic [40:0] s, input logic [47:0] p);
    longint pa, pb;
    logic [47:0] m, z;
    pa = longint'($signed(s[35:18]));
    pb = longint'($signed(s[17:0]));
    m  = (s[40:39] == 2'b01) ? 48'(pa * pb) : 48'd0;
    z  = (s[38:37] == 2'b10) ? p : 48'd0;
    return s[36] ? z - m : z + m;
  endfunction
  always @(posedge clk) begin
    s1   <= {o_dsp_opmode_x, o_dsp_opmode_z, o_dsp_postadd_sub, o_dsp_a, o_dsp_b};
    s2   <= s1;
    pout <= next_p(s2, pout);
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic beat(input int id, input logic signed [17:0] a, input logic signed [17:0] b,
                      input logic sub, input logic last, input logic [1:0] ez);
    ra[id*18 +: 18] = a;
    rb[id*18 +: 18] = b;
    sb[id] = sub;
    lst[id] = last;
    vld[id] = 1'b1;
    #1;
    for (int i = 0; i < 20 && !o_req_ready[id]; i++) begin
      @(negedge clk);
      #1;
    end
    chk("beat_ready", 64'(o_req_ready), 64'(4'b1 << id));
    chk("beat_opmode", {o_dsp_opmode_x, o_dsp_opmode_z, o_dsp_postadd_sub}, {2'b01, ez, sub});
    chk("beat_oper", {o_dsp_a, o_dsp_b}, {a, b});
    t_acc = cyc;
    @(negedge clk);
    vld[id] = 1'b0;
    lst[id] = 1'b0;
    sb[id] = 1'b0;
  endtask
  task automatic wait_res(input string tag, input logic [47:0] d, input int id, input int cnt);
    #1;
    for (int i = 0; i < 20 && !o_res_valid; i++) begin
      @(negedge clk);
      #1;
    end
    chk({tag, "_valid"}, o_res_valid, 1);
    chk({tag, "_lat"}, cyc - t_acc, 4);
    chk({tag, "_data"}, o_res_data, d);
    chk({tag, "_id"}, o_res_id, id);
    chk({tag, "_cnt"}, o_res_cnt, cnt);
    @(negedge clk);
    #1;
    chk({tag, "_pulse"}, {o_res_valid, o_res_data}, {1'b0, d});
  endtask
  task automatic rr_run(input logic [3:0] mask, input logic [7:0] order, input int n);
    int g = 0, r = 0;
    logic [3:0] clr = '0;
    for (int i = 0; i < 4; i++)
      if (mask[i]) begin
        ra[i*18 +: 18] = 18'(i + 1);
        rb[i*18 +: 18] = 18'd1;
        lst[i] = 1'b1;
      end
    vld = vld | mask;
    for (int c = 0; c < 80 && r < n; c++) begin
      @(negedge clk);
      vld = vld & ~clr;
      #1;
      clr = o_req_ready;
      if (o_req_ready != '0) begin
        chk("rr_grant", 64'(o_req_ready), 64'(4'b1 << order[2*g +: 2]));
        g++;
      end
      if (o_res_valid) begin
        chk("rr_id", o_res_id, order[2*r +: 2]);
        chk("rr_data", o_res_data, order[2*r +: 2] + 1);
        r++;
      end
    end
    chk("rr_count", r, n);
    vld = '0;
    lst = '0;
  endtask
  initial begin
    int pulses;
    @(negedge clk);
    #1;
    chk("rst_ready", o_req_ready, 0);
    chk("rst_opmode", {o_dsp_opmode_x, o_dsp_opmode_z, o_dsp_postadd_sub}, 5'b00100);
    chk("rst_res", {o_res_valid, o_res_id, o_res_data, o_res_cnt, o_busy}, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    beat(0, 3, 4, 1'b0, 1'b0, 2'b00);
    beat(0, -2, 5, 1'b0, 1'b1, 2'b10);
    wait_res("job0", 48'd2, 0, 2);
    @(negedge clk);
    beat(1, 100, -7, 1'b1, 1'b1, 2'b00);
    wait_res("sub", 48'h0000_0000_02BC, 1, 1);
    @(negedge clk);
    beat(2, 1, 1, 1'b0, 1'b0, 2'b00);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bubble_hold", {o_busy, o_dsp_opmode_x, o_dsp_opmode_z, o_dsp_postadd_sub}, 6'b100100);
      @(negedge clk);
    end
    beat(2, 1, 1, 1'b0, 1'b1, 2'b10);
    wait_res("bubble", 48'd2, 2, 2);
    @(negedge clk);
    for (int i = 0; i < 4; i++) beat(0, -131072, -131072, 1'b0, i == 3, i == 0 ? 2'b00 : 2'b10);
    wait_res("ext", 48'h10_0000_0000, 0, 4);
    @(negedge clk);
    for (int i = 0; i < 300; i++) beat(1, 1, 1, 1'b0, i == 299, i == 0 ? 2'b00 : 2'b10);
    wait_res("long", 48'd300, 1, 255);
    @(negedge clk);
    beat(3, 5, 5, 1'b0, 1'b0, 2'b00);
    beat(3, 5, 5, 1'b0, 1'b0, 2'b10);
    #2 reset = 1'b1;
    #1;
    chk("midrst_out", {o_busy, o_req_ready, o_dsp_opmode_x, o_dsp_opmode_z, o_dsp_postadd_sub}, 10'b0000000100);
    chk("midrst_res", {o_res_valid, o_res_id, o_res_data, o_res_cnt}, 0);
    @(negedge clk);
    reset = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (o_res_valid) pulses++;
    end
    chk("midrst_nores", pulses, 0);
    beat(3, 2, 3, 1'b0, 1'b1, 2'b00);
    wait_res("after_rst", 48'd6, 3, 1);
    rr_run(4'b1111, 8'b11100100, 4);
    rr_run(4'b0101, 8'b00001000, 2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
